// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU with a start/busy/done handshake and registered result and flags.
// The optional iterative multiplier is built only when ULA_MUL_EN is defined.
// Without it, opcode 011 behaves as reserved: result 0, carry 0, single cycle.
//
// Handshake: `start` is sampled on a rising edge only while busy=0. That edge captures
// OpSelect/A/Ry. `busy` stays high until the result is written. `done` pulses for one
// cycle with result/flags valid. `start` may be high in the done cycle to chain ops.
module ula_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       OpSelect,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Ry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic [1:0]       state_dbg
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    steps;
  logic [SHW-1:0]   shamt;
  logic             multi;
  logic             accept;
  logic [WIDTH-1:0] res_c;
  logic             cy_c;
`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     hi_sum;
`endif

  assign shamt     = Ry[SHW-1:0];
  assign accept    = start && (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Decide whether the requested op needs iteration, and how many steps it needs.
  always_comb begin
    multi = 1'b0;
    steps = '0;
    case (OpSelect)
`ifdef ULA_MUL_EN
      3'b011: begin
        multi = 1'b1;
        steps = CW'(WIDTH);
      end
`endif
      3'b101, 3'b110: begin
        multi = (shamt != '0);
        steps = {1'b0, shamt};
      end
      default: begin
        multi = 1'b0;
        steps = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic. DONE is the write-back cycle; the done pulse follows it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = multi ? EXEC : DONE;
      EXEC:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ULA_MUL_EN
  // One shift-add step: add the multiplicand to the high half when the current multiplier bit is set.
  assign hi_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
`endif

  // Final result and carry from the captured operands or the iteration registers.
  always_comb begin
    res_c = '0;
    cy_c  = 1'b0;
    case (op_r)
      3'b000:         {cy_c, res_c} = {1'b0, a_r} + {1'b0, b_r};
      3'b001:         {cy_c, res_c} = {1'b0, a_r} - {1'b0, b_r};
      3'b010:         res_c = ~(a_r & b_r);
`ifdef ULA_MUL_EN
      3'b011: begin
        res_c = prod[WIDTH-1:0];
        cy_c  = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      3'b100:         res_c = a_r;
      3'b101, 3'b110: res_c = a_r;
      default: begin
        res_c = '0;
        cy_c  = 1'b0;
      end
    endcase
  end

  // Operand capture, per-step iteration, and registered result/flags at write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      negative <= 1'b0;
      carry    <= 1'b0;
`ifdef ULA_MUL_EN
      prod     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_r <= OpSelect;
        a_r  <= A;
        b_r  <= Ry;
        cnt  <= steps;
`ifdef ULA_MUL_EN
        prod <= {{WIDTH{1'b0}}, Ry};
`endif
      end
      if (state == EXEC) begin
        cnt <= cnt - CW'(1);
        case (op_r)
          3'b101:  a_r <= a_r << 1;
          3'b110:  a_r <= a_r >> 1;
`ifdef ULA_MUL_EN
          3'b011:  prod <= {hi_sum, prod[WIDTH-1:1]};
`endif
          default: a_r <= a_r;
        endcase
      end
      if (state == DONE) begin
        result   <= res_c;
        zero     <= (res_c == '0);
        negative <= res_c[WIDTH-1];
        carry    <= cy_c;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed-vector bench for ula_seq (WIDTH=16) with hand-computed expectations.
// Mul expectations follow ULA_MUL_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_ula_seq;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   OpSelect;
  logic [W-1:0] A, Ry;
  logic         busy, done, zero, negative, carry;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ula_seq #(.WIDTH(W), .SHW(4)) dut (
    .clock(clock), .reset(reset), .start(start), .OpSelect(OpSelect),
    .A(A), .Ry(Ry), .busy(busy), .done(done), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int           total = 0;
  int           bad   = 0;
  int           k_edge = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents an op before a rising edge; that edge accepts it and is recorded as k.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; OpSelect = op; A = a; Ry = b;
    @(posedge clock);
    #1;
    k_edge = cyc;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, sampling 1ns after each rising edge; lat = edges since k.
  task automatic wait_done(output int lat);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    lat = cyc - k_edge;
    if (!got) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_res,
                        input logic [2:0] exp_znc);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back(exp_res);
    start_op(op, a, b);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(lat);
    e = exp_q.pop_front();
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, {16'd0, result}, {16'd0, e});
    check({tag, "_znc"}, {29'd0, zero, negative, carry}, {29'd0, exp_znc});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; OpSelect = '0; A = '0; Ry = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", {16'd0, result}, 32'd0);
    check("rst_znc", {29'd0, zero, negative, carry}, 32'b100);
    @(negedge clock);
    reset = 1'b0;

    // single-cycle ops: {zero, negative, carry}
    run_op("add", 3'b000, 16'd2, 16'd1, 1, 16'd3, 3'b000);
    run_op("add_ovf", 3'b000, 16'hFFFF, 16'd1, 1, 16'h0000, 3'b101);
    run_op("sub", 3'b001, 16'd6, 16'd2, 1, 16'd4, 3'b000);
    run_op("sub_brw", 3'b001, 16'd2, 16'd6, 1, 16'hFFFC, 3'b011);
    run_op("nand", 3'b010, 16'd1, 16'd0, 1, 16'hFFFF, 3'b010);
    run_op("out", 3'b100, 16'd7, 16'd9, 1, 16'd7, 3'b000);
    run_op("rsvd", 3'b111, 16'd5, 16'd3, 1, 16'd0, 3'b100);

`ifdef ULA_MUL_EN
    run_op("mul", 3'b011, 16'd300, 16'd200, 17, 16'hEA60, 3'b010);
    run_op("mul_hi", 3'b011, 16'h0100, 16'h0100, 17, 16'h0000, 3'b101);
`else
    run_op("mul_off", 3'b011, 16'd300, 16'd200, 1, 16'h0000, 3'b100);
    run_op("mul_off_hi", 3'b011, 16'h0100, 16'h0100, 1, 16'h0000, 3'b100);
`endif

    // shifts
    run_op("shl15", 3'b101, 16'd1, 16'd15, 16, 16'h8000, 3'b010);
    run_op("shr0", 3'b110, 16'h8000, 16'd0, 1, 16'h8000, 3'b010);
    run_op("shr3", 3'b110, 16'h8000, 16'h0013, 4, 16'h1000, 3'b000);

    // start pulses during a long op are ignored and operands are not re-sampled
`ifdef ULA_MUL_EN
    start_op(3'b011, 16'd300, 16'd200);
`else
    start_op(3'b101, 16'd1, 16'd15);
`endif
    repeat (2) @(posedge clock);
    #1; start = 1'b1; OpSelect = 3'b000; A = 16'd1; Ry = 16'd1;
    @(posedge clock);
    #1; start = 1'b0;
    repeat (4) @(posedge clock);
    #1; start = 1'b1; A = 16'd4;
    @(posedge clock);
    #1; start = 1'b0;
    wait_done(lat);
`ifdef ULA_MUL_EN
    check("ign_lat", lat, 17);
    check("ign_res", {16'd0, result}, 32'h0000EA60);
`else
    check("ign_lat", lat, 16);
    check("ign_res", {16'd0, result}, 32'h00008000);
`endif
    @(posedge clock);
    #1;
    check("ign_idle", {31'd0, busy}, 32'd0);

    // start held high through an op: accepted again right in the done cycle
    @(negedge clock);
    start = 1'b1; OpSelect = 3'b000; A = 16'd2; Ry = 16'd1;
    @(posedge clock);
    #1;
    k_edge = cyc;
    OpSelect = 3'b100; A = 16'd7; Ry = 16'd0;
    wait_done(lat);
    check("b2b_lat1", lat, 1);
    check("b2b_res1", {16'd0, result}, 32'd3);
    @(posedge clock);
    #1;
    check("b2b_accept", {31'd0, busy}, 32'd1);
    k_edge = cyc;
    start = 1'b0;
    wait_done(lat);
    check("b2b_lat2", lat, 1);
    check("b2b_res2", {16'd0, result}, 32'd7);
    @(posedge clock);

    // reset in the middle of a long op
    start_op(3'b101, 16'd1, 16'd15);
    repeat (5) @(posedge clock);
    #1; reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_res", {16'd0, result}, 32'd0);
    check("mid_rst_znc", {29'd0, zero, negative, carry}, 32'b100);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (done) done_seen++;
    end
    check("mid_rst_nodone", done_seen, 0);
    run_op("add_after_rst", 3'b000, 16'd2, 16'd1, 1, 16'd3, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
